trace_buffer: RTL and testbench
===============================

# trace_buffer

Debug trace buffer between the subleq CPU and the seven-segment debug display. It records the last 16 values of a CPU-side debug word (typically the IP), one per CPU step, in a 16-entry ring. The operator can freeze the ring and scroll back through the history with push-buttons. It runs on the board clock, and all control inputs are treated as asynchronous.

## Interface
- DATA_WIDTH, 64, width of the captured word and of oData
- ADDR_WIDTH, 4, log2 of ring depth (depth = 16)
- iClock  in  1  board clock (CLOCK_50); sole clock of the block
- iReset  in  1  synchronous, active-high reset
- iCapture  in  1  capture request (e.g. the CPU step clock); each rising edge captures one word
- iData  in  DATA_WIDTH  word to capture; must be stable for ≥3 iClock cycles after an iCapture rise
- iFreeze  in  1  level: 1 = frozen/browse mode, 0 = live mode
- iStepBack  in  1  button level; each rising edge moves the view one entry older
- iStepFwd  in  1  button level; each rising edge moves the view one entry newer
- oData  out  DATA_WIDTH  entry currently viewed; 0 when the ring is empty
- oIndex  out  ADDR_WIDTH  view offset; 0 = newest entry
- oCount  out  ADDR_WIDTH+1  valid entries, 0..16
- oFull  out  1  oCount == 16
- oFrozen  out  1  current mode (1 = FROZEN)
- oDropped  out  8  captures ignored while frozen; saturates at 255

## Operation
- **Input conditioning.** iCapture, iFreeze, iStepBack and iStepFwd each pass through a 2-flop synchronizer (s1→s2).
  - Edge pulses are s2 & ~s2_d, where s2_d is s2 delayed one cycle. This applies to capture, back and fwd.
  - Freeze uses the s2 level only.
- **Storage.** 16 × DATA_WIDTH register array, a write pointer wp (ADDR_WIDTH bits, wraps 15→0), count (0..16) and view offset off.
- **States.** Two states, LIVE (reset state) and FROZEN; oFrozen = (state == FROZEN).
  - LIVE→FROZEN when the synchronized freeze level = 1. FROZEN→LIVE when it = 0.
  - Entering LIVE forces off = 0.
- **LIVE mode.**
  - Capture pulse: mem[wp] ← iData, wp ← wp+1, count ← min(count+1, 16).
  - Step pulses are ignored; off stays 0.
- **FROZEN mode.**
  - Capture pulse: no write, no pointer change; oDropped ← min(oDropped+1, 255).
  - Back pulse alone: off ← off+1 if off < count−1, else unchanged.
  - Fwd pulse alone: off ← off−1 if off > 0, else unchanged.
  - Back and fwd pulses in the same cycle: off unchanged.
- **Precedence.** The mode is evaluated from the registered state at the start of the cycle.
  - A capture pulse in the same cycle as the LIVE→FROZEN transition is still written.
  - A capture pulse in the same cycle as FROZEN→LIVE is dropped and counted.
- **Read path.** oData = mem[(wp − 1 − off) mod 16], combinational from the registers, when count > 0; otherwise oData = 0. oIndex = off. oFull = (count == 16).
- **Wrap-around.** The 17th and later captures overwrite the oldest entry; count stays 16.
- **Reset.** state = LIVE, wp = 0, count = 0, off = 0, oDropped = 0, synchronizers and delay flops = 0. Memory contents are not cleared, but oData = 0 because count = 0.
  - Reset values of outputs: oData 0, oIndex 0, oCount 0, oFull 0, oFrozen 0, oDropped 0.
  - Reset asserted mid-operation discards all history on the next edge.

## Timing
- Define edge k as the first iClock edge that samples an input high.
  - s2 = 1 after edge k+1.
  - The pulse is active in the following cycle, and its effect registers at edge k+2.
  - Outputs reflect the effect after edge k+2: a 3-edge latency from first sample.
- Freeze level follows the same path; oFrozen changes after edge k+2.
- oData and oIndex are valid in the same cycle that wp, off or count update (combinational read).
- A continuously held button produces exactly one pulse. It must be released for ≥1 synchronized cycle before the next pulse is generated.
- Capture inputs may change no faster than once per 4 iClock cycles; faster toggling may merge edges (not checked).

## Test plan
- **Reset.** Hold iReset 2 cycles with random inputs → all outputs 0; after release, oCount = 0 and oData = 0.
- **Basic capture.** Three captures of 0x11, 0x22, 0x33 in LIVE → oCount = 3, oData = 0x33, oIndex = 0. Each update lands exactly 3 edges after iCapture is first sampled high.
- **Wrap-around.** 20 captures of values 1..20 → oCount = 16, oFull = 1, oData = 20. Freeze, then 15 back pulses → oIndex = 15, oData = 5. A 16th back pulse leaves oIndex = 15.
- **Browse limits.** 3 entries (0xA, 0xB, 0xC), frozen: back ×5 → oIndex = 2, oData = 0xA. Fwd ×4 → oIndex = 0, oData = 0xC. Back and fwd raised in the same cycle → oIndex unchanged.
- **Dropped captures.** Frozen with 2 entries, 300 capture edges → oCount = 2, data unchanged, oDropped = 255. Unfreeze → oIndex = 0; the next capture is written and oCount = 3.
- **Mid-operation reset.** Frozen at oIndex = 4 with 10 entries; assert iReset 1 cycle → oFrozen = 0, oCount = 0, oIndex = 0, oData = 0, oDropped = 0, even though iFreeze is still high. oFrozen returns to 1 three edges after reset release.

Source files
------------

// File: rtl/trace_buffer.sv
// trace_buffer: 16-deep debug-word history ring with freeze/browse; in: iClock, iReset, iCapture, iData, iFreeze, iStepBack, iStepFwd; out: oData, oIndex, oCount, oFull, oFrozen, oDropped
module trace_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iCapture,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iFreeze,
  input  logic                  iStepBack,
  input  logic                  iStepFwd,
  output logic [DATA_WIDTH-1:0] oData,
  output logic [ADDR_WIDTH-1:0] oIndex,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oFrozen,
  output logic [7:0]            oDropped
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {LIVE, FROZEN} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [2:0] s3_q, s3_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d, off_q, off_d, rd_idx;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [7:0] drop_q, drop_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic live, cap, back, fwd, frz, wr, can_back;
  always_comb begin
    s1_d = {iStepFwd, iStepBack, iFreeze, iCapture};
    s2_d = s1_q;
    s3_d = {s2_q[3:2], s2_q[0]};
    cap = s2_q[0] & ~s3_q[0];
    frz = s2_q[1];
    back = s2_q[2] & ~s3_q[1];
    fwd = s2_q[3] & ~s3_q[2];
    live = state_q == LIVE;
    wr = live && cap;
    state_d = frz ? FROZEN : LIVE;
    wp_d = wp_q + ADDR_WIDTH'(wr);
    cnt_d = (wr && cnt_q != (ADDR_WIDTH+1)'(DEPTH)) ? cnt_q + (ADDR_WIDTH+1)'(1) : cnt_q;
    drop_d = (!live && cap && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    can_back = ({1'b0, off_q} + (ADDR_WIDTH+1)'(1)) < cnt_q;
    off_d = (live || !frz) ? '0 :
            (back && !fwd && can_back) ? off_q + ADDR_WIDTH'(1) :
            (fwd && !back && off_q != '0) ? off_q - ADDR_WIDTH'(1) : off_q;
    rd_idx = wp_q - off_q - ADDR_WIDTH'(1);
  end
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= LIVE;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      wp_q <= '0;
      off_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      wp_q <= wp_d;
      off_q <= off_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge iClock) begin
    if (wr && !iReset) mem_q[wp_q] <= iData;
  end
  assign oData = (cnt_q != '0) ? mem_q[rd_idx] : '0;
  assign oIndex = off_q;
  assign oCount = cnt_q;
  assign oFull = cnt_q == (ADDR_WIDTH+1)'(DEPTH);
  assign oFrozen = state_q == FROZEN;
  assign oDropped = drop_q;
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: scoreboard bench for trace_buffer with directed vectors
module tb_trace_buffer;
  logic clk = 0;
  logic rst = 0;
  logic cap = 0, frz = 0, bk = 0, fw = 0;
  logic [63:0] din = '0;
  logic [63:0] o_data;
  logic [3:0] o_index;
  logic [4:0] o_count;
  logic o_full, o_frozen;
  logic [7:0] o_dropped;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  typedef struct {
    int due;
    string nm;
    logic [63:0] d;
    logic [3:0] idx;
    logic [4:0] cnt;
    logic full;
    logic frz;
    logic [7:0] drop;
  } exp_t;
  exp_t sb[$];
  trace_buffer dut (
    .iClock(clk), .iReset(rst), .iCapture(cap), .iData(din), .iFreeze(frz),
    .iStepBack(bk), .iStepFwd(fw), .oData(o_data), .oIndex(o_index),
    .oCount(o_count), .oFull(o_full), .oFrozen(o_frozen), .oDropped(o_dropped)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.due == cyc && {o_data, o_index, o_count, o_full, o_frozen, o_dropped} ===
          {e.d, e.idx, e.cnt, e.full, e.frz, e.drop})
        passed++;
      else
        $display("FAIL %s @%0d: got data=%h idx=%0d cnt=%0d full=%b frozen=%b drop=%0d, want data=%h idx=%0d cnt=%0d full=%b frozen=%b drop=%0d",
                 e.nm, cyc, o_data, o_index, o_count, o_full, o_frozen, o_dropped,
                 e.d, e.idx, e.cnt, e.full, e.frz, e.drop);
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic expect_at(int due, string nm, logic [63:0] d, logic [3:0] idx,
                           logic [4:0] cnt, logic f, logic [7:0] drop);
    exp_t e;
    e.due = due; e.nm = nm; e.d = d; e.idx = idx; e.cnt = cnt;
    e.full = (cnt == 5'd16); e.frz = f; e.drop = drop;
    sb.push_back(e);
  endtask
  task automatic expect_now(string nm, logic [63:0] d, logic [3:0] idx,
                            logic [4:0] cnt, logic f, logic [7:0] drop);
    expect_at(cyc, nm, d, idx, cnt, f, drop);
  endtask
  task automatic capture(logic [63:0] v);
    din = v; cap = 1; tick(4);
    cap = 0; tick(4);
  endtask
  task automatic press(logic b, logic f);
    bk = b; fw = f; tick(3);
    bk = 0; fw = 0; tick(3);
  endtask
  task automatic do_reset();
    rst = 1; cap = 0; bk = 0; fw = 0; frz = 0; tick(2);
    rst = 0; tick(2);
  endtask
  initial begin
    int c;
    tick(1);
    rst = 1;
    cap = 1'($urandom); frz = 1'($urandom); bk = 1'($urandom); fw = 1'($urandom);
    din = {$urandom, $urandom};
    tick(1);
    expect_now("reset_held", 0, 0, 0, 0, 0);
    tick(1);
    expect_now("reset_held2", 0, 0, 0, 0, 0);
    rst = 0; cap = 0; frz = 0; bk = 0; fw = 0;
    tick(4);
    expect_now("after_reset", 0, 0, 0, 0, 0);
    c = cyc; din = 64'h11; cap = 1;
    expect_at(c + 2, "cap_lat_before", 0, 0, 0, 0, 0);
    expect_at(c + 3, "cap_lat_edge3", 64'h11, 0, 1, 0, 0);
    tick(4); cap = 0; tick(4);
    capture(64'h22);
    capture(64'h33);
    expect_now("basic_3", 64'h33, 0, 3, 0, 0);
    total++;
    if (o_data === 64'h33 && o_count === 5'd3) passed++;
    else $display("FAIL direct_basic: data=%h cnt=%0d", o_data, o_count);
    do_reset();
    for (int v = 1; v <= 20; v++) capture(64'(v));
    expect_now("wrap_full", 64'd20, 0, 16, 0, 0);
    frz = 1; tick(4);
    expect_now("wrap_frozen", 64'd20, 0, 16, 1, 0);
    press(1, 0);
    expect_now("wrap_back1", 64'd19, 1, 16, 1, 0);
    for (int i = 0; i < 14; i++) press(1, 0);
    expect_now("wrap_back15", 64'd5, 15, 16, 1, 0);
    press(1, 0);
    expect_now("wrap_back16", 64'd5, 15, 16, 1, 0);
    total++;
    if (o_index === 4'd15 && o_data === 64'd5) passed++;
    else $display("FAIL direct_wrap: idx=%0d data=%h", o_index, o_data);
    do_reset();
    capture(64'hA); capture(64'hB); capture(64'hC);
    frz = 1; tick(4);
    expect_now("browse_frozen", 64'hC, 0, 3, 1, 0);
    for (int i = 0; i < 5; i++) press(1, 0);
    expect_now("browse_back5", 64'hA, 2, 3, 1, 0);
    press(0, 1);
    expect_now("browse_fwd1", 64'hB, 1, 3, 1, 0);
    for (int i = 0; i < 3; i++) press(0, 1);
    expect_now("browse_fwd4", 64'hC, 0, 3, 1, 0);
    press(1, 0);
    expect_now("browse_back_b", 64'hB, 1, 3, 1, 0);
    press(1, 1);
    expect_now("browse_both", 64'hB, 1, 3, 1, 0);
    total++;
    if (o_index === 4'd1 && o_data === 64'hB) passed++;
    else $display("FAIL direct_both: idx=%0d data=%h", o_index, o_data);
    do_reset();
    capture(64'h55);
    frz = 1; din = 64'h66; cap = 1; tick(4); cap = 0; tick(4);
    expect_now("freeze_with_cap", 64'h66, 0, 2, 1, 0);
    for (int i = 0; i < 300; i++) begin
      din = 64'(i) + 64'h1000; cap = 1; tick(2);
      cap = 0; tick(2);
      if (i == 9) expect_now("drop_10", 64'h66, 0, 2, 1, 8'd10);
    end
    expect_now("drop_sat", 64'h66, 0, 2, 1, 8'd255);
    press(1, 0);
    expect_now("drop_back", 64'h55, 1, 2, 1, 8'd255);
    frz = 0; din = 64'h99; cap = 1; tick(4); cap = 0; tick(4);
    expect_now("unfreeze_cap_dropped", 64'h66, 0, 2, 0, 8'd255);
    capture(64'h77);
    expect_now("live_again", 64'h77, 0, 3, 0, 8'd255);
    do_reset();
    for (int v = 1; v <= 10; v++) capture(64'h100 + 64'(v));
    frz = 1; tick(4);
    for (int i = 0; i < 4; i++) press(1, 0);
    capture(64'hDEAD);
    expect_now("mid_pre", 64'h106, 4, 10, 1, 8'd1);
    c = cyc; rst = 1; tick(1);
    expect_now("mid_reset", 0, 0, 0, 0, 0);
    rst = 0;
    expect_at(c + 3, "mid_rel_edge2", 0, 0, 0, 0, 0);
    expect_at(c + 4, "mid_rel_edge3", 0, 0, 0, 1, 0);
    tick(6);
    total += sb.size();
    sb.delete();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
